rs5_plic: RTL and testbench

- Platform-level interrupt controller for the RS5 SoC. Memory-mapped in the 0x3..0x7 region of the RS5 data bus.
- Collects `i_cnt` external interrupt sources and applies per-source priority and enable, plus a global threshold.
- Drives a single machine-external-interrupt line (mei) into the core.
- Claim is triggered by the core's interrupt acknowledge; completion is a bus write.

---
 rtl/rs5_plic.sv | 108 ++++++++++
 tb/tb_rs5_plic.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rs5_plic.sv
// rs5_plic: platform-level interrupt controller with per-source priority/enable,
// a global threshold, level gateways and a single claim/complete slot driving mei.
module rs5_plic #(
    parameter int i_cnt = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [3:0]       we_i,
    input  logic [23:0]      addr_i,
    input  logic [31:0]      data_i,
    output logic [31:0]      data_o,
    input  logic [i_cnt-1:0] irq_i,
    input  logic             iack_i,
    output logic [i_cnt-1:0] iack_o,
    output logic             irq_o
);
    localparam logic [21:0] w_pend  = 22'h000400;
    localparam logic [21:0] w_en    = 22'h000800;
    localparam logic [21:0] w_thr   = 22'h080000;
    localparam logic [21:0] w_claim = 22'h080001;

    logic [2:0]       prio_q [i_cnt];
    logic [2:0]       prio_d [i_cnt];
    logic [i_cnt-1:0] enable_q, enable_d, pending_q, pending_d;
    logic [i_cnt-1:0] closed_q, closed_d, iack_q, iack_d;
    logic [2:0]       thresh_q, thresh_d, best;
    logic [4:0]       claim_q, claim_d, cand;
    logic [31:0]      data_q, data_d, rdata;
    logic [21:0]      word;
    logic             wr, rd, complete, take;

    assign word     = addr_i[23:2];
    assign wr       = en_i && (we_i != 4'b0);
    assign rd       = en_i && (we_i == 4'b0);
    assign complete = wr && we_i[0] && (word == w_claim) && (claim_q != 5'd0) && (data_i[4:0] == claim_q);
    assign take     = iack_i && (cand != 5'd0) && (claim_q == 5'd0) && !complete;
    assign irq_o    = (cand != 5'd0) && (claim_q == 5'd0);
    assign data_o   = data_q;
    assign iack_o   = iack_q;

    // Strict '>' keeps the lowest ID on priority ties; starting at the threshold masks prio <= threshold.
    always_comb begin
        cand = 5'd0;
        best = thresh_q;
        for (int k = 0; k < i_cnt; k++)
            if (pending_q[k] && enable_q[k] && prio_q[k] > best) begin
                best = prio_q[k];
                cand = 5'(k + 1);
            end
    end

    always_comb begin
        rdata = 32'd0;
        for (int k = 0; k < i_cnt; k++)
            if (word == 22'(k + 1)) rdata = {29'd0, prio_q[k]};
        if (word == w_pend)  rdata = 32'({pending_q, 1'b0});
        if (word == w_en)    rdata = 32'({enable_q, 1'b0});
        if (word == w_thr)   rdata = {29'd0, thresh_q};
        if (word == w_claim) rdata = {27'd0, claim_q};
    end

    always_comb begin
        prio_d    = prio_q;
        enable_d  = enable_q;
        pending_d = pending_q;
        closed_d  = closed_q;
        iack_d    = '0;
        for (int k = 0; k < i_cnt; k++) begin
            if (wr && we_i[0] && word == 22'(k + 1)) prio_d[k] = data_i[2:0];
            if (wr && word == w_en && we_i[(k + 1) / 8]) enable_d[k] = data_i[k + 1];
            if (irq_i[k] && !closed_q[k] && !pending_q[k]) begin
                pending_d[k] = 1'b1;
                closed_d[k]  = 1'b1;
            end
            if (take && cand == 5'(k + 1)) begin
                pending_d[k] = 1'b0;
                iack_d[k]    = 1'b1;
            end
            if (complete && claim_q == 5'(k + 1)) closed_d[k] = 1'b0;
        end
        thresh_d = (wr && we_i[0] && word == w_thr) ? data_i[2:0] : thresh_q;
        claim_d  = complete ? 5'd0 : take ? cand : claim_q;
        data_d   = rd ? rdata : data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < i_cnt; k++) prio_q[k] <= 3'd0;
            enable_q  <= '0;
            pending_q <= '0;
            closed_q  <= '0;
            iack_q    <= '0;
            thresh_q  <= 3'd0;
            claim_q   <= 5'd0;
            data_q    <= 32'd0;
        end else begin
            prio_q    <= prio_d;
            enable_q  <= enable_d;
            pending_q <= pending_d;
            closed_q  <= closed_d;
            iack_q    <= iack_d;
            thresh_q  <= thresh_d;
            claim_q   <= claim_d;
            data_q    <= data_d;
        end
    end
endmodule

// File: tb/tb_rs5_plic.sv
// tb_rs5_plic: directed and random checks of rs5_plic (4 sources) against a behavioural model.
module tb_rs5_plic;
    logic        clk = 1'b0, reset = 1'b0, en = 1'b0, iack = 1'b0;
    logic [3:0]  we = 4'd0, irq = 4'd0;
    logic [23:0] addr = 24'd0;
    logic [31:0] din = 32'd0;
    logic [31:0] dout;
    logic [3:0]  iack_out;
    logic        irq_out;
    int          total = 0, bad = 0;

    logic [2:0]  m_prio [1:4];
    logic [4:0]  m_en, m_pend, m_open;
    logic [2:0]  m_thr;
    int          m_claim;
    logic [31:0] m_data;
    logic [3:0]  m_iack;

    rs5_plic #(.i_cnt(4)) dut (
        .clk(clk), .reset(reset), .en_i(en), .we_i(we), .addr_i(addr), .data_i(din),
        .data_o(dout), .irq_i(irq), .iack_i(iack), .iack_o(iack_out), .irq_o(irq_out)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Highest priority level first, then lowest ID within that level.
    function automatic int m_cand();
        for (int p = 7; p > int'(m_thr); p--)
            for (int id = 1; id <= 4; id++)
                if (m_pend[id] && m_en[id] && int'(m_prio[id]) == p) return id;
        return 0;
    endfunction

    function automatic logic [31:0] m_read(logic [23:0] a);
        int w;
        w = int'(a[23:2]);
        if (w >= 1 && w <= 4) return {29'd0, m_prio[w]};
        if (w == 'h400)   return {27'd0, m_pend[4:1], 1'b0};
        if (w == 'h800)   return {27'd0, m_en[4:1], 1'b0};
        if (w == 'h80000) return {29'd0, m_thr};
        if (w == 'h80001) return 32'(m_claim);
        return 32'd0;
    endfunction

    task automatic tick();
        int          c, w;
        bit          wr_, cmp, tk;
        logic [31:0] rv;
        c   = m_cand();
        w   = int'(addr[23:2]);
        wr_ = en && we != 4'd0;
        cmp = wr_ && we[0] && w == 'h80001 && m_claim != 0 && din[4:0] == 5'(m_claim);
        tk  = iack && c != 0 && m_claim == 0 && !cmp;
        rv  = m_read(addr);
        @(posedge clk);
        #1;
        m_iack = 4'd0;
        for (int id = 1; id <= 4; id++)
            if (irq[id-1] && m_open[id] && !m_pend[id]) begin
                m_pend[id] = 1'b1;
                m_open[id] = 1'b0;
            end
        if (tk) begin
            m_pend[c]     = 1'b0;
            m_iack[c-1]   = 1'b1;
            m_claim       = c;
        end
        if (cmp) begin
            m_open[m_claim] = 1'b1;
            m_claim         = 0;
        end
        if (wr_) begin
            if (we[0] && w >= 1 && w <= 4) m_prio[w] = din[2:0];
            if (w == 'h800)
                for (int id = 1; id <= 4; id++) if (we[id/8]) m_en[id] = din[id];
            if (we[0] && w == 'h80000) m_thr = din[2:0];
        end
        if (en && we == 4'd0) m_data = rv;
        chk("data_o", dout, m_data);
        chk("iack_o", 32'(iack_out), 32'(m_iack));
        chk("irq_o", 32'(irq_out), 32'(m_cand() != 0 && m_claim == 0));
        en   = 1'b0;
        we   = 4'd0;
        iack = 1'b0;
    endtask

    task automatic wr(logic [23:0] a, logic [31:0] d, logic [3:0] w);
        addr = a; din = d; we = w; en = 1'b1;
        tick();
    endtask

    task automatic rd(logic [23:0] a, logic [31:0] exp);
        addr = a; we = 4'd0; en = 1'b1;
        tick();
        chk($sformatf("read %h", a), dout, exp);
    endtask

    logic [23:0] amap [11] = '{24'h4, 24'h8, 24'hC, 24'h10, 24'h14, 24'h1000, 24'h2000,
                               24'h200000, 24'h200004, 24'h100000, 24'h0};

    initial begin
        for (int id = 1; id <= 4; id++) m_prio[id] = 3'd0;
        m_en = 5'd0; m_pend = 5'd0; m_open = 5'b11110; m_thr = 3'd0;
        m_claim = 0; m_data = 32'd0; m_iack = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset data_o", dout, 32'd0);
        chk("reset iack_o", 32'(iack_out), 32'd0);
        chk("reset irq_o", 32'(irq_out), 32'd0);
        reset = 1'b1;
        rd(24'h1000, 0); rd(24'h2000, 0); rd(24'h200000, 0); rd(24'h200004, 0);

        wr(24'h4, 3, 4'hF); wr(24'h2000, 2, 4'hF); wr(24'h200000, 0, 4'hF);
        irq = 4'b0001; tick();
        chk("basic irq_o", 32'(irq_out), 1);
        rd(24'h1000, 2);
        iack = 1'b1; tick();
        chk("basic iack_o", 32'(iack_out), 1);
        chk("claimed irq_o", 32'(irq_out), 0);
        tick();
        chk("iack one cycle", 32'(iack_out), 0);
        rd(24'h200004, 1);
        irq = 4'b0000; tick(); irq = 4'b0001; tick();
        rd(24'h1000, 0);
        wr(24'h200004, 2, 4'hF);
        rd(24'h200004, 1);
        wr(24'h200004, 1, 4'hF);
        tick();
        chk("repend irq_o", 32'(irq_out), 1);
        rd(24'h1000, 2);

        wr(24'h4, 2, 4'hF); wr(24'h200000, 2, 4'hF);
        chk("thr masked irq_o", 32'(irq_out), 0);
        rd(24'h1000, 2);
        wr(24'h200000, 1, 4'hF);
        chk("thr open irq_o", 32'(irq_out), 1);
        iack = 1'b1; tick();
        irq = 4'b0000; wr(24'h200004, 1, 4'hF);

        wr(24'h8, 5, 4'hF); wr(24'hC, 5, 4'hF); wr(24'h10, 6, 4'hF); wr(24'h2000, 32'h1E, 4'hF);
        irq = 4'b1110; tick();
        iack = 1'b1; tick();
        rd(24'h200004, 4);
        irq = 4'b0110; wr(24'h200004, 4, 4'hF);
        iack = 1'b1; tick();
        rd(24'h200004, 2);
        irq = 4'b0000; iack = 1'b1; wr(24'h200004, 2, 4'hF);
        rd(24'h200004, 0);
        chk("complete+iack irq_o", 32'(irq_out), 1);

        wr(24'h200000, 0, 4'hF);
        wr(24'h200000, 32'hFFFF_FFFF, 4'b0010);
        rd(24'h200000, 0);
        rd(24'h100000, 0);
        rd(24'h14, 0);
        rd(24'hA, 5);

        for (int i = 0; i < 1500; i++) begin
            int j;
            if ($urandom_range(0, 3) == 0) irq = 4'($urandom);
            iack = ($urandom_range(0, 3) == 0);
            j    = $urandom_range(0, 10);
            addr = amap[j] | 24'($urandom_range(0, 3));
            en   = ($urandom_range(0, 2) != 0);
            we   = ($urandom_range(0, 1) == 0) ? 4'd0 : ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            din  = (j == 8) ? 32'($urandom_range(0, 4)) : $urandom;
            tick();
        end

        rd(24'h200000, {29'd0, m_thr});
        reset = 1'b0;
        #2;
        chk("async reset data_o", dout, 32'd0);
        chk("async reset irq_o", 32'(irq_out), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
